// File: rtl/cpu_defs.sv
// Shared CPU definitions for the fetch stage and its next-PC generator.
//  - B-type compare codes driven by decode
//  - reset PC / bubble instruction defaults
//  - fetch FSM state encoding
//  - bundle of decode-side branch/jump information
package cpu_defs;
  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  localparam logic [3:0] type_BEQ = 4'b0001;
  localparam logic [3:0] type_BNE = 4'b0000;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } fe_state_t;

  typedef struct packed {
    logic        is_b;
    logic        is_j;
    logic        is_jr;
    logic [3:0]  b_type;
    logic [15:0] b_offset;
    logic [25:0] j_index;
    logic [31:0] rs_value;
    logic [31:0] rt_value;
  } br_req_t;
endpackage

// File: rtl/fetch_stage_npc_gen.sv
// npc_gen: combinational next-fetch-address select.
// Ports:
//  fetch_pc  in  32  address currently being read (delay slot when a branch is in decode)
//  fe_pc     in  32  PC of the instruction sitting in decode
//  br        in      decode branch/jump info and forwarded operands
//  npc       out 32  next fetch address (may be misaligned for JR)
//  taken     out 1   a branch/jump is redirecting the fetch stream
module npc_gen
  import cpu_defs::*;
(
  input  logic [31:0] fetch_pc,
  input  logic [31:0] fe_pc,
  input  br_req_t     br,
  output logic [31:0] npc,
  output logic        taken
);
  logic [31:0] seq_pc, dly_pc, b_tgt, j_tgt;
  logic        ops_eq, b_taken;

  assign seq_pc  = fetch_pc + 32'd4;
  // Targets are relative to the delay slot, i.e. the branch PC + 4.
  assign dly_pc  = fe_pc + 32'd4;
  assign b_tgt   = dly_pc + {{14{br.b_offset[15]}}, br.b_offset, 2'b00};
  assign j_tgt   = {dly_pc[31:28], br.j_index, 2'b00};
  assign ops_eq  = (br.rs_value == br.rt_value);
  assign b_taken = br.is_b & ((br.b_type == type_BEQ) ? ops_eq : ~ops_eq);

  always_comb begin
    npc   = seq_pc;
    taken = 1'b0;
    if (br.is_jr) begin
      npc   = br.rs_value;
      taken = 1'b1;
    end else if (br.is_j) begin
      npc   = j_tgt;
      taken = 1'b1;
    end else if (b_taken) begin
      npc   = b_tgt;
      taken = 1'b1;
    end
  end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: IF stage of the 5-stage MIPS pipeline. Owns the PC, drives the
// synchronous-read instruction SRAM, and applies branch/jump redirects resolved
// in decode (one architectural delay slot, never squashed).
// Ports:
//  clk, resetn                 clock / async active-low reset
//  stall                       hold from hazard unit
//  de_is_b/j/jr, de_b_type,
//  de_b_offset, de_j_index,
//  de_rs_value, de_rt_value    decode branch/jump info and operands
//  inst_sram_en/addr/rdata     SRAM read port (data one cycle after addr)
//  fe_inst, current_pc         instruction and its PC to decode
//  fe_valid                    fe_inst is real (else bubble)
//  fe_redirect                 one-cycle pulse after a redirect edge
//  fe_adel                     sticky misaligned-fetch flag
module fetch_stage #(
  parameter logic [31:0] RESET_PC = cpu_defs::RESET_PC,
  parameter logic [31:0] NOP_INST = cpu_defs::NOP_INST
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        stall,
  input  logic        de_is_b,
  input  logic        de_is_j,
  input  logic        de_is_jr,
  input  logic [3:0]  de_b_type,
  input  logic [15:0] de_b_offset,
  input  logic [25:0] de_j_index,
  input  logic [31:0] de_rs_value,
  input  logic [31:0] de_rt_value,
  output logic        inst_sram_en,
  output logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_rdata,
  output logic [31:0] fe_inst,
  output logic [31:0] current_pc,
  output logic        fe_valid,
  output logic        fe_redirect,
  output logic        fe_adel
);
  import cpu_defs::*;

  fe_state_t   st, st_nx;
  logic [31:0] fetch_pc, fe_pc, inst_buf, npc;
  logic        taken, adv;
  br_req_t     br;

  assign br = '{is_b: de_is_b, is_j: de_is_j, is_jr: de_is_jr,
                b_type: de_b_type, b_offset: de_b_offset, j_index: de_j_index,
                rs_value: de_rs_value, rt_value: de_rt_value};

  npc_gen u_npc (
    .fetch_pc (fetch_pc),
    .fe_pc    (fe_pc),
    .br       (br),
    .npc      (npc),
    .taken    (taken)
  );

  // adv: PCs step forward this edge (and a redirect, if any, is applied).
  always_comb begin
    st_nx = st;
    adv   = 1'b0;
    unique case (st)
      ST_BOOT: st_nx = ST_RUN;
      ST_RUN:  if (stall) st_nx = ST_HOLD; else adv = 1'b1;
      ST_HOLD: if (!stall) begin st_nx = ST_RUN; adv = 1'b1; end
      default: st_nx = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) st <= ST_BOOT;
    else         st <= st_nx;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fetch_pc    <= RESET_PC;
      fe_pc       <= 32'd0;
      inst_buf    <= NOP_INST;
      fe_valid    <= 1'b0;
      fe_redirect <= 1'b0;
      fe_adel     <= 1'b0;
    end else begin
      fe_redirect <= adv & taken;
      if (st == ST_BOOT) begin
        fe_pc    <= RESET_PC;
        fetch_pc <= RESET_PC + 32'd4;
        fe_valid <= 1'b1;
      end
      // While held the SRAM re-reads fetch_pc, so the decode word must be captured.
      if (st == ST_RUN && stall) inst_buf <= inst_sram_rdata;
      if (adv) begin
        fe_pc    <= fetch_pc;
        fetch_pc <= npc & ~32'd3;
        if (npc[1:0] != 2'b00) fe_adel <= 1'b1;
      end
    end
  end

  assign inst_sram_en   = 1'b1;
  assign inst_sram_addr = fetch_pc;

  always_comb begin
    fe_inst = NOP_INST;
    if (fe_valid) fe_inst = (st == ST_HOLD) ? inst_buf : inst_sram_rdata;
  end

  assign current_pc = fe_valid ? fe_pc : 32'd0;
endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
  localparam logic [31:0] RST = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        resetn;
  logic        stall, de_is_b, de_is_j, de_is_jr;
  logic [3:0]  de_b_type;
  logic [15:0] de_b_offset;
  logic [25:0] de_j_index;
  logic [31:0] de_rs_value, de_rt_value;
  logic        inst_sram_en;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_rdata = 32'd0;
  logic [31:0] fe_inst, current_pc;
  logic        fe_valid, fe_redirect, fe_adel;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .resetn(resetn), .stall(stall),
    .de_is_b(de_is_b), .de_is_j(de_is_j), .de_is_jr(de_is_jr),
    .de_b_type(de_b_type), .de_b_offset(de_b_offset), .de_j_index(de_j_index),
    .de_rs_value(de_rs_value), .de_rt_value(de_rt_value),
    .inst_sram_en(inst_sram_en), .inst_sram_addr(inst_sram_addr),
    .inst_sram_rdata(inst_sram_rdata),
    .fe_inst(fe_inst), .current_pc(current_pc), .fe_valid(fe_valid),
    .fe_redirect(fe_redirect), .fe_adel(fe_adel)
  );

  // SRAM contents: a distinct word per address.
  function automatic logic [31:0] memw(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hA5C3_0F96;
  endfunction

  always @(posedge clk) if (inst_sram_en) inst_sram_rdata <= memw(inst_sram_addr);

  initial begin
    #2_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] pc, input logic [31:0] addr,
                         input logic vld, input logic red, input logic adel);
    chk({tag, ".pc"},   current_pc, pc);
    chk({tag, ".addr"}, inst_sram_addr, addr);
    chk({tag, ".vld"},  {31'd0, fe_valid}, {31'd0, vld});
    chk({tag, ".inst"}, fe_inst, vld ? memw(pc) : 32'd0);
    chk({tag, ".red"},  {31'd0, fe_redirect}, {31'd0, red});
    chk({tag, ".adel"}, {31'd0, fe_adel}, {31'd0, adel});
    chk({tag, ".en"},   {31'd0, inst_sram_en}, 32'd1);
  endtask

  task automatic set_in(input logic s, input logic b, input logic j, input logic jr,
                        input logic [3:0] bt, input logic [15:0] off, input logic [25:0] idx,
                        input logic [31:0] rs, input logic [31:0] rt);
    stall = s; de_is_b = b; de_is_j = j; de_is_jr = jr; de_b_type = bt;
    de_b_offset = off; de_j_index = idx; de_rs_value = rs; de_rt_value = rt;
  endtask

  task automatic clear_in();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0, 26'h0, 32'h0, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    clear_in();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic go(input int n);
    repeat (n) begin clear_in(); @(negedge clk); end
  endtask

  typedef struct {
    logic        s, b, j, jr;
    logic [3:0]  bt;
    logic [15:0] off;
    logic [25:0] idx;
    logic [31:0] rs, rt;
    logic [31:0] pc, addr;
    logic        red, adel;
  } vec_t;

  vec_t tbl[9];

  // behavioural model for the random phase
  logic        m_valid, m_red, m_adel;
  logic [31:0] m_cur, m_nxt;

  task automatic model_reset();
    m_valid = 1'b0; m_red = 1'b0; m_adel = 1'b0; m_cur = 32'd0; m_nxt = RST;
  endtask

  task automatic model_step();
    logic [31:0] dly, tgt, offw;
    logic        tk;
    if (!m_valid) begin
      m_valid = 1'b1; m_cur = RST; m_nxt = RST + 32'd4; m_red = 1'b0;
    end else if (stall) begin
      m_red = 1'b0;
    end else begin
      dly  = m_cur + 32'd4;
      offw = {{16{de_b_offset[15]}}, de_b_offset};
      tk   = 1'b1;
      if (de_is_jr)     tgt = de_rs_value;
      else if (de_is_j) tgt = {dly[31:28], de_j_index, 2'b00};
      else if (de_is_b && ((de_b_type == 4'b0001) == (de_rs_value == de_rt_value)))
                        tgt = dly + offw * 32'd4;
      else begin tk = 1'b0; tgt = m_nxt + 32'd4; end
      m_cur = m_nxt;
      m_nxt = {tgt[31:2], 2'b00};
      m_red = tk;
      if (tk && tgt[1:0] != 2'b00) m_adel = 1'b1;
    end
  endtask

  initial begin
    resetn = 1'b0;
    clear_in();

    tbl[0] = '{1'b0,1'b0,1'b0,1'b0,4'h0,16'h0,26'h0,32'h0,32'h0,32'hBFC0_0000,32'hBFC0_0004,1'b0,1'b0};
    tbl[1] = '{1'b0,1'b0,1'b0,1'b0,4'h0,16'h0,26'h0,32'h0,32'h0,32'hBFC0_0004,32'hBFC0_0008,1'b0,1'b0};
    tbl[2] = '{1'b0,1'b0,1'b0,1'b0,4'h0,16'h0,26'h0,32'h0,32'h0,32'hBFC0_0008,32'hBFC0_000C,1'b0,1'b0};
    tbl[3] = '{1'b0,1'b0,1'b1,1'b0,4'h0,16'h0,26'h40,32'h0,32'h0,32'hBFC0_000C,32'hB000_0100,1'b1,1'b0};
    tbl[4] = '{1'b0,1'b0,1'b0,1'b0,4'h0,16'h0,26'h0,32'h0,32'h0,32'hB000_0100,32'hB000_0104,1'b0,1'b0};
    tbl[5] = '{1'b0,1'b0,1'b0,1'b1,4'h0,16'h0,26'h0,32'h8000_0002,32'h0,32'hB000_0104,32'h8000_0000,1'b1,1'b1};
    tbl[6] = '{1'b0,1'b0,1'b0,1'b0,4'h0,16'h0,26'h0,32'h0,32'h0,32'h8000_0000,32'h8000_0004,1'b0,1'b1};
    tbl[7] = '{1'b1,1'b0,1'b0,1'b0,4'h0,16'h0,26'h0,32'h0,32'h0,32'h8000_0000,32'h8000_0004,1'b0,1'b1};
    tbl[8] = '{1'b0,1'b0,1'b0,1'b0,4'h0,16'h0,26'h0,32'h0,32'h0,32'h8000_0004,32'h8000_0008,1'b0,1'b1};

    repeat (2) @(negedge clk);
    chk_all("rst", 32'd0, RST, 1'b0, 1'b0, 1'b0);
    resetn = 1'b1;
    #1 chk_all("boot", 32'd0, RST, 1'b0, 1'b0, 1'b0);

    // straight line, J, misaligned JR, one stall
    for (int i = 0; i < 9; i++) begin
      set_in(tbl[i].s, tbl[i].b, tbl[i].j, tbl[i].jr, tbl[i].bt, tbl[i].off,
             tbl[i].idx, tbl[i].rs, tbl[i].rt);
      @(negedge clk);
      chk_all($sformatf("tbl%0d", i), tbl[i].pc, tbl[i].addr, 1'b1, tbl[i].red, tbl[i].adel);
    end

    // BEQ taken at BFC00010: delay slot then target
    do_reset();
    go(5);
    chk_all("beq.pre", 32'hBFC0_0010, 32'hBFC0_0014, 1'b1, 1'b0, 1'b0);
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 4'b0001, 16'h0003, 26'h0, 32'd5, 32'd5);
    @(negedge clk);
    chk_all("beq.ds", 32'hBFC0_0014, 32'hBFC0_0020, 1'b1, 1'b1, 1'b0);
    go(1);
    chk_all("beq.tgt", 32'hBFC0_0020, 32'hBFC0_0024, 1'b1, 1'b0, 1'b0);

    // BNE with equal operands: falls through
    do_reset();
    go(5);
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 16'h0003, 26'h0, 32'd7, 32'd7);
    @(negedge clk);
    chk_all("bne.ds", 32'hBFC0_0014, 32'hBFC0_0018, 1'b1, 1'b0, 1'b0);
    go(1);
    chk_all("bne.seq", 32'hBFC0_0018, 32'hBFC0_001C, 1'b1, 1'b0, 1'b0);

    // stall 3 cycles with BEQ in decode; operands settle only at release
    do_reset();
    go(5);
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 1'b1, 1'b0, 1'b0, 4'b0001, 16'h0003, 26'h0, 32'd5 + i, 32'd9);
      @(negedge clk);
      chk_all($sformatf("stl%0d", i), 32'hBFC0_0010, 32'hBFC0_0014, 1'b1, 1'b0, 1'b0);
    end
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 4'b0001, 16'h0003, 26'h0, 32'd9, 32'd9);
    @(negedge clk);
    chk_all("stl.rel", 32'hBFC0_0014, 32'hBFC0_0020, 1'b1, 1'b1, 1'b0);
    go(1);
    chk_all("stl.tgt", 32'hBFC0_0020, 32'hBFC0_0024, 1'b1, 1'b0, 1'b0);

    // async reset while stalled, with fe_adel set
    do_reset();
    go(3);
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 16'h0, 26'h0, 32'h0000_1003, 32'h0);
    @(negedge clk);
    chk_all("ar.jr", 32'hBFC0_000C, 32'h0000_1000, 1'b1, 1'b1, 1'b1);
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0, 26'h0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    chk_all("ar.hold", 32'hBFC0_000C, 32'h0000_1000, 1'b1, 1'b0, 1'b1);
    #2 resetn = 1'b0;
    #1 chk_all("ar.async", 32'd0, RST, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    clear_in();
    resetn = 1'b1;
    @(negedge clk);
    chk_all("ar.restart", RST, RST + 32'd4, 1'b1, 1'b0, 1'b0);

    // randomized run against the model
    do_reset();
    model_reset();
    #1 chk_all("rnd.rst", m_cur, m_nxt, m_valid, m_red, m_adel);
    for (int c = 0; c < 600; c++) begin
      int k;
      logic [31:0] rs;
      if (c == 300) begin do_reset(); model_reset(); end
      k  = $urandom_range(0, 11);
      rs = $urandom;
      if ($urandom_range(0, 7) != 0) rs[1:0] = 2'b00;
      set_in($urandom_range(0, 3) == 0, k == 0 || k == 3, k == 1 || k == 3, k == 2 || k == 3,
             $urandom_range(0, 1) ? 4'b0001 : 4'b0000, 16'($urandom), 26'($urandom),
             rs, $urandom_range(0, 1) ? rs : $urandom);
      model_step();
      @(negedge clk);
      chk_all($sformatf("rnd%0d", c), m_cur, m_nxt, m_valid, m_red, m_adel);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
